// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file with a sequential post-reset clear sweep.
// Storage is a plain array without reset so it can map onto distributed RAM.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_INIT | clear sweep: zero mem[cnt] each cycle, reads forced to 0
// S_RUN  | normal operation: writes accepted, reads from array or bypass
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // The sweep owns the write port in INIT, so user writes are simply dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = WriteReg;
    mem_wdata = WriteData;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) state_d = S_RUN;
    end else if (RegWrite && (WriteReg != '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready = (state_q == S_RUN);

  always_comb begin
    ReadData1 = '0;
    if (ready && (ReadReg1 != '0)) begin
      if ((BYPASS != 0) && RegWrite && (WriteReg == ReadReg1)) ReadData1 = WriteData;
      else                                                     ReadData1 = mem_q[ReadReg1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ready && (ReadReg2 != '0)) begin
      if ((BYPASS != 0) && RegWrite && (WriteReg == ReadReg2)) ReadData2 = WriteData;
      else                                                     ReadData2 = mem_q[ReadReg2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a write-first instance and a BYPASS=0 instance
// share the same stimulus; outputs are sampled on the falling edge or between edges.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0;
  logic [31:0] WriteData = '0;
  logic        RegWrite = 1'b0;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        ready, ready_nb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1), .ReadData2(rd2), .ready(ready)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb), .ready(ready_nb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks 32 sweep edges, checking ready on both instances and forced-zero reads.
  task automatic sweep(input string tag, input bit drop_wr_at_end);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (drop_wr_at_end && k == 32) RegWrite = 1'b0;
      @(negedge clk);
      check({tag, " ready"}, {31'b0, ready}, {31'b0, (k == 32)});
      check({tag, " ready_nb"}, {31'b0, ready_nb}, {31'b0, (k == 32)});
      if (k < 32) check({tag, " rd1 in init"}, rd1, 32'h0);
    end
  endtask

  initial begin
    // Reset state, then first sweep (array contents start unknown).
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd17;
    @(negedge clk);
    check("reset ready", {31'b0, ready}, 32'h0);
    check("reset rd1", rd1, 32'h0);
    check("reset rd2", rd2, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sweep("sweep1", 1'b0);

    // Fill every register with all-ones.
    RegWrite  = 1'b1;
    WriteData = 32'hFFFF_FFFF;
    for (int r = 1; r < 32; r++) begin
      WriteReg = r[4:0];
      step();
    end
    RegWrite = 1'b0;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd31;
    #1;
    check("preload r5", rd1, 32'hFFFF_FFFF);
    check("preload r31 nb", rd2_nb, 32'hFFFF_FFFF);

    // Reset with a write to r3 held high through reset and the whole sweep.
    RegWrite  = 1'b1;
    WriteReg  = 5'd3;
    WriteData = 32'h0000_00AA;
    ReadReg1  = 5'd3;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sweep("sweep2", 1'b1);
    for (int r = 1; r < 32; r++) begin
      ReadReg1 = r[4:0];
      ReadReg2 = r[4:0];
      #1;
      check($sformatf("cleared r%0d p1", r), rd1, 32'h0);
      check($sformatf("cleared r%0d p2 nb", r), rd2_nb, 32'h0);
    end

    // Basic write/read.
    RegWrite  = 1'b1;
    WriteReg  = 5'd5;
    WriteData = 32'hDEAD_BEEF;
    step();
    WriteReg  = 5'd31;
    WriteData = 32'h1234_5678;
    step();
    RegWrite = 1'b0;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd31;
    #1;
    check("basic rd1", rd1, 32'hDEAD_BEEF);
    check("basic rd2", rd2, 32'h1234_5678);
    check("basic rd1 nb", rd1_nb, 32'hDEAD_BEEF);
    check("basic rd2 nb", rd2_nb, 32'h1234_5678);

    // Register 0 stays zero, including during the write cycle.
    RegWrite  = 1'b1;
    WriteReg  = 5'd0;
    WriteData = 32'hCAFE_F00D;
    ReadReg1  = 5'd0;
    ReadReg2  = 5'd0;
    #1;
    check("r0 during write p1", rd1, 32'h0);
    check("r0 during write p2", rd2, 32'h0);
    step();
    RegWrite = 1'b0;
    #1;
    check("r0 after write p1", rd1, 32'h0);
    check("r0 after write p2 nb", rd2_nb, 32'h0);

    // Bypass vs. no-bypass on a same-cycle write to r7.
    RegWrite  = 1'b1;
    WriteReg  = 5'd7;
    WriteData = 32'h11;
    step();
    WriteData = 32'h22;
    ReadReg1  = 5'd7;
    ReadReg2  = 5'd5;
    #1;
    check("bypass rd1", rd1, 32'h22);
    check("no-bypass rd1", rd1_nb, 32'h11);
    check("bypass indep rd2", rd2, 32'hDEAD_BEEF);
    step();
    RegWrite = 1'b0;
    #1;
    check("post-edge rd1", rd1, 32'h22);
    check("post-edge rd1 nb", rd1_nb, 32'h22);

    // Reset mid-sweep restarts the full 32-edge sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("midsweep ready", {31'b0, ready}, 32'h0);
    end
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    sweep("sweep3", 1'b0);
    #1;
    check("r7 cleared after resweep", rd1, 32'h0);
    check("r5 cleared after resweep", rd2_nb, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

32-entry × 32-bit general-purpose register file for the single-cycle datapath. It receives the destination register number chosen by the register-destination selector (WriteReg), the write data from the writeback path and the RegWrite control signal, and it supplies the two source operands to the ALU stage. Storage is written as a plain memory array so it maps to FPGA distributed RAM. For that reason, registers are cleared by a sequential post-reset sweep rather than a single-cycle parallel reset. Register 0 reads as zero at all times.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register-number width; depth = 2**ADDR_W
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports (write-first)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ReadReg1  input  ADDR_W  source register number, port 1
- ReadReg2  input  ADDR_W  source register number, port 2
- WriteReg  input  ADDR_W  destination register number
- WriteData  input  DATA_W  data to write
- RegWrite  input  1  write enable
- ReadData1  output  DATA_W  operand 1 (combinational)
- ReadData2  output  DATA_W  operand 2 (combinational)
- ready  output  1  high when the clear sweep is done and the file accepts writes

## Operation
- There are two states: INIT (clear sweep) and RUN. A sweep counter `cnt` of ADDR_W bits is associated with INIT.
- rst high at an edge sets state to INIT and cnt to 0. This applies in any state, including mid-sweep; the sweep restarts from 0.
- In INIT, each edge with rst low writes 0 to mem[cnt] and increments cnt.
  - When cnt == 2**ADDR_W−1 is written, the state becomes RUN at that same edge.
  - cnt wraps to 0. Its value is don't-care in RUN.
- In INIT:
  - ready = 0.
  - RegWrite is ignored.
  - ReadData1 and ReadData2 are forced to 0.
- In RUN:
  - ready = 1.
  - At each edge with RegWrite = 1 and WriteReg ≠ 0, WriteData is written to mem[WriteReg].
  - A write to register 0 is discarded.
- Reads in RUN:
  - If ReadRegN == 0, ReadDataN = 0.
  - Otherwise, if BYPASS = 1, RegWrite = 1 and WriteReg == ReadRegN, then ReadDataN = WriteData.
  - Otherwise, ReadDataN = mem[ReadRegN].
- Both read ports are independent. They may address the same register, or the register being written, in the same cycle.
- Values are stored full width with no truncation or extension.

## Timing
- Reset values: ready = 0, ReadData1 = 0, ReadData2 = 0. These hold throughout INIT.
- Sweep latency: after the last edge with rst high, ready rises after exactly 2**ADDR_W edges (32 at default).
- Reads are zero-latency combinational from ReadReg*, and also from WriteReg, WriteData and RegWrite when BYPASS = 1.
- Writes take effect at the rising edge. With BYPASS = 0, the new value is visible on the read ports in the cycle after the edge.
- When rst and RegWrite are high at the same edge, rst wins and no write occurs.
- When the sweep completes and RegWrite is high at the same edge, the write is ignored because the state is still INIT when sampled.
- No handshake is used: the datapath must hold off PC advance until ready = 1.

## Test plan
- Reset sweep:
  - Stimulus: assert rst for 2 cycles, then release. Preload all registers beforehand through backdoor writes to 0xFFFFFFFF.
  - Required response: ready = 0 for exactly 32 edges, then 1. Reading registers 1–31 afterwards returns 0x00000000 on each.
- Basic write/read:
  - Stimulus: write 0xDEADBEEF to register 5 and 0x12345678 to register 31. Then read them on ReadReg1 = 5 and ReadReg2 = 31.
  - Required response: ReadData1 = 0xDEADBEEF and ReadData2 = 0x12345678.
- Register 0:
  - Stimulus: RegWrite = 1, WriteReg = 0, WriteData = 0xCAFEF00D. Then set ReadReg1 = ReadReg2 = 0.
  - Required response: both ports read 0, including during the write cycle itself.
- Bypass:
  - Stimulus: BYPASS = 1, register 7 holds 0x11. Drive RegWrite = 1, WriteReg = 7, WriteData = 0x22 and ReadReg1 = 7 in the same cycle.
  - Required response: ReadData1 = 0x22 before the edge.
  - Repeat with BYPASS = 0. Required response: ReadData1 = 0x11 before the edge and 0x22 after it.
- Writes during INIT:
  - Stimulus: RegWrite = 1 to register 3 with data 0xAA on every sweep cycle.
  - Required response: register 3 reads 0 once ready = 1.
- Reset mid-sweep:
  - Stimulus: assert rst for 1 cycle at sweep cycle 10.
  - Required response: ready stays low for a full 32 edges after the second reset.
